// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the serial modular add/sub block.
// Holds op encodings, FSM state type and default sizing.
package mod_arith_pkg;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_LIMB  = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/limb_addsub.sv
// One limb of add or subtract with 1-bit carry/borrow in and out.
// For subtract, o_cout is the borrow out of x - y - cin.
module limb_addsub #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] i_x,
    input  logic [LIMB-1:0] i_y,
    input  logic            i_cin,
    input  logic            i_sub,
    output logic [LIMB-1:0] o_s,
    output logic            o_cout
);

    logic [LIMB:0] w_sum;
    logic [LIMB:0] w_x;
    logic [LIMB:0] w_y;
    logic [LIMB:0] w_c;

    assign w_x = {1'b0, i_x};
    assign w_y = {1'b0, i_y};
    assign w_c = {{LIMB{1'b0}}, i_cin};

    // Single adder/subtractor, bit LIMB carries the carry or borrow
    always_comb begin
        w_sum = '0;
        if (i_sub) begin
            w_sum = w_x - w_y - w_c;
        end else begin
            w_sum = w_x + w_y + w_c;
        end
    end

    assign o_s    = w_sum[LIMB-1:0];
    assign o_cout = w_sum[LIMB];

endmodule

// File: rtl/mod_addsub_serial.sv
// Limb-serial (a +/- b) mod p with valid/ready on both sides.
// Define MOD_ADDSUB_RANGE_CHECK_EN to build the a/b < p range check.
module mod_addsub_serial
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMB  = DEF_LIMB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             range_err
);

    localparam int NLIMB = WIDTH / LIMB;
    localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_t1;
    logic [WIDTH-1:0] r_t2;
    logic [WIDTH-1:0] r_result;
    logic             r_op;
    logic             r_c1;
    logic             r_c2;

    logic             w_accept;
    logic             w_last;
    logic             w_sel_t2;
    logic [LIMB-1:0]  w_al;
    logic [LIMB-1:0]  w_bl;
    logic [LIMB-1:0]  w_pl;
    logic [LIMB-1:0]  w_t1l;
    logic [LIMB-1:0]  w_t2l;
    logic             w_c1n;
    logic             w_c2n;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_idx == IW'(NLIMB - 1));

    // Operand registers shift right, so the current limb is always at the bottom
    assign w_al = r_a[LIMB-1:0];
    assign w_bl = r_b[LIMB-1:0];
    assign w_pl = r_p[LIMB-1:0];

    // t1 = a +/- b, t2 = t1 -/+ p, both chains in the same cycle
    limb_addsub #(.LIMB(LIMB)) u_t1 (
        .i_x    (w_al),
        .i_y    (w_bl),
        .i_cin  (r_c1),
        .i_sub  (r_op == OP_SUB),
        .o_s    (w_t1l),
        .o_cout (w_c1n)
    );

    limb_addsub #(.LIMB(LIMB)) u_t2 (
        .i_x    (w_t1l),
        .i_y    (w_pl),
        .i_cin  (r_c2),
        .i_sub  (r_op == OP_ADD),
        .o_s    (w_t2l),
        .o_cout (w_c2n)
    );

    // Add: t2 when the sum overflowed or t1 >= p; sub: t2 when a < b
    assign w_sel_t2 = (r_op == OP_ADD) ? (r_c1 || !r_c2) : r_c1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = CALC;
            CALC:    if (w_last) w_next = FINAL;
            FINAL:   w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Limb-serial datapath, new limbs enter t1/t2 from the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_t1     <= '0;
            r_t2     <= '0;
            r_result <= '0;
            r_op     <= 1'b0;
            r_c1     <= 1'b0;
            r_c2     <= 1'b0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_a   <= a;
            r_b   <= b;
            r_p   <= p;
            r_op  <= op;
            r_t1  <= '0;
            r_t2  <= '0;
            r_c1  <= 1'b0;
            r_c2  <= 1'b0;
        end else if (r_state == CALC) begin
            r_idx <= r_idx + 1'b1;
            r_a   <= r_a >> LIMB;
            r_b   <= r_b >> LIMB;
            r_p   <= r_p >> LIMB;
            r_t1  <= (r_t1 >> LIMB) | (WIDTH'(w_t1l) << (WIDTH - LIMB));
            r_t2  <= (r_t2 >> LIMB) | (WIDTH'(w_t2l) << (WIDTH - LIMB));
            r_c1  <= w_c1n;
            r_c2  <= w_c2n;
        end else if (r_state == FINAL) begin
            r_result <= w_sel_t2 ? r_t2 : r_t1;
        end
    end

    assign result = r_result;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic r_ba;
    logic r_bb;
    logic r_err;

    // Borrow chains of a - p and b - p; no final borrow means x >= p
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ba  <= 1'b0;
            r_bb  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_ba  <= 1'b0;
            r_bb  <= 1'b0;
        end else if (r_state == CALC) begin
            r_ba <= (w_al < w_pl) || ((w_al == w_pl) && r_ba);
            r_bb <= (w_bl < w_pl) || ((w_bl == w_pl) && r_bb);
        end else if (r_state == FINAL) begin
            r_err <= !r_ba || !r_bb;
        end
    end

    assign range_err = r_err;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: doc/mod_addsub_serial.md
MOD_ADDSUB_SERIAL -- requirements
Module: mod_addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 256, meaning operand/modulus width in bits.
REQ-002 SHALL have parameter LIMB, default 64, meaning bits processed per cycle; WIDTH % LIMB == 0 is required; NLIMB = WIDTH/LIMB.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands, op and modulus presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a, b  input  WIDTH  operands; a < p and b < p are required.
REQ-008 p  input  WIDTH  modulus; p > 0.
REQ-009 op  input  1  0 = (a+b) mod p, 1 = (a-b) mod p.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  modular sum or difference.
REQ-013 range_err  output  1  operand range violation flag, qualified by out_valid.

Function
REQ-014 SHALL use FSM states IDLE, CALC, FINAL and DONE.
REQ-015 SHALL assert in_ready only in IDLE; an accept is in_valid && in_ready on a rising edge.
REQ-016 On accept, SHALL register a, b, p and op, clear the limb index and carries, and enter CALC.
REQ-017 In CALC, SHALL compute t1 = a±b limb i with carry/borrow c1 and t2 = t1∓p limb i with borrow/carry c2, one limb per cycle, LSB limb first, both chains in the same cycle.
REQ-018 After limb NLIMB-1, SHALL enter FINAL.
REQ-019 FINAL, add: SHALL select t2 if c1 == 1 or the final t2 borrow == 0, else t1.
REQ-020 FINAL, sub: SHALL select t2 if the final t1 borrow == 1, else t1.
REQ-021 FINAL SHALL take exactly 1 cycle and then enter DONE.
REQ-022 out_valid SHALL rise exactly NLIMB+1 cycles after the accepting edge (5 cycles for defaults).
REQ-023 In DONE, out_valid SHALL be 1, and result and range_err SHALL hold stable until out_valid && out_ready.
REQ-024 On out_valid && out_ready, SHALL return to IDLE, with in_ready = 1 the next cycle; there is no input/output overlap.
REQ-025 Input changes while not in IDLE SHALL have no effect.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH on internal registers; limb carries are 1 bit.

Reset
REQ-027 On rst_n low, at any time including mid-CALC, the FSM SHALL go to IDLE and the limb index, carries and internal registers SHALL clear to 0.
REQ-028 Reset values SHALL be: in_ready = 1, out_valid = 0, result = 0, range_err = 0.
REQ-029 An operation in flight during reset SHALL be discarded with no output produced.

Configuration
REQ-030 The macro MOD_ADDSUB_RANGE_CHECK_EN SHALL control the range check.
REQ-031 When MOD_ADDSUB_RANGE_CHECK_EN is defined, CALC SHALL additionally run limb-serial compares of a and b against p, and range_err SHALL be 1 in DONE if a >= p or b >= p; the result value is then unspecified.
REQ-032 When MOD_ADDSUB_RANGE_CHECK_EN is undefined, no compare logic SHALL be built and range_err SHALL be tied to 0.

Structure
REQ-033 The shared package mod_arith_pkg SHALL hold the op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1, the FSM state enum typedef, and the default WIDTH/LIMB constants.
REQ-034 Sub-module limb_addsub SHALL implement one LIMB-wide add/sub with carry-in/out and be instantiated once per chain (t1, t2).

Verification (defaults, p = 2^256 - 2^32 - 977)
REQ-035 add, a = p-1, b = 1 -> result = 0, range_err = 0, out_valid exactly 5 cycles after accept.
REQ-036 sub, a = 0, b = 1 -> result = p-1; sub, a = 5, b = 5 -> result = 0.
REQ-037 add, a = b = 2^255 -> result = 0x1000003D1.
REQ-038 out_ready held low for 10 cycles in DONE -> out_valid stays 1, result stays stable, in_ready stays 0; the first cycle after the handshake shows in_ready = 1.
REQ-039 rst_n pulsed low on the 2nd CALC cycle -> out_valid = 0 and in_ready = 1 after release; a following add, a = 3, b = 4 -> result = 7.
REQ-040 add, a = p, b = 0 -> range_err = 1 with MOD_ADDSUB_RANGE_CHECK_EN, 0 without.
